serial_display_mux: RTL and testbench
=====================================

// Module: serial_display_mux
// PURPOSE
//  Off-chip-side consumer of the clock's 3-wire serial display stream (data/clk/latch).
//  Deserialises each 48-bit frame (6 digits x 8 segment bits) and validates its bit count.
//  Drives a time-multiplexed common-cathode 6-digit 7-segment display.
//  Replaces the external shift-register chain in the FPGA demo build.
// PARAMETERS
//  SYS_CLK_HZ    5_000_000  system clock frequency
//  SCAN_HZ       6_000      digit-advance rate (1 kHz refresh per digit at 6 digits)
//  BLANK_CYCLES  16         all-digits-off guard after each digit change (anti-ghosting)
// PORTS
//  i_clk           in   1  system clock; all logic on posedge
//  i_reset_n       in   1  asynchronous, active-low reset
//  i_en            in   1  display enable; low = outputs blanked, scan held
//  i_serial_data   in   1  serial data, asynchronous to i_clk, sampled on i_serial_clk rise
//  i_serial_clk    in   1  shift clock, asynchronous to i_clk
//  i_serial_latch  in   1  frame latch, asynchronous to i_clk, acts on rising edge
//  o_segments      out  8  active-high segments {dp,g,f,e,d,c,b,a} of the selected digit
//  o_digit_sel     out  6  one-hot active-high digit select; bit 5 = hours MSB
//  o_frame_stb     out  1  one-cycle pulse: valid frame committed
//  o_frame_err     out  1  one-cycle pulse: latch seen with bit count != 48
// BEHAVIOUR
//  Reset: shift reg, frame reg, bit count, prescaler, digit index, blank counter = 0;
//   all outputs 0.
//  Sync: the three serial inputs pass 2-FF synchronisers; rise = sync & ~prev.
//   Latency from pin edge to action: 3 i_clk cycles.
//  Shift: on data-clock rise, shift_reg <= {shift_reg[46:0], data_sync};
//   bit_cnt++ (saturates at 63). The first bit received lands in frame[47].
//  Latch rise with bit_cnt == 48: frame_reg <= shift_reg; o_frame_stb = 1 next cycle.
//  Latch rise with bit_cnt != 48 (incl. 0): frame_reg unchanged; o_frame_err = 1 next cycle.
//  Any latch rise clears bit_cnt to 0.
//  Same-cycle clk rise + latch rise: the shift happens first; the latch sees the new
//   shift_reg and bit_cnt+1.
//  Digit k content = frame_reg[8k+7:8k].
//  Scan: prescaler counts 0..SYS_CLK_HZ/SCAN_HZ-1. On wrap, digit index advances
//   0->1->..->5->0 and blank counter loads BLANK_CYCLES.
//  While blank counter != 0: o_digit_sel = 0, o_segments = 0, counter decrements.
//  Otherwise: o_digit_sel = 1<<idx, o_segments = digit[idx].
//   Outputs are registered, 1 cycle after idx/frame change.
//  i_en low: prescaler and index hold; o_digit_sel = o_segments = 0.
//   Deserialising and frame commit continue.
//  Frame commit mid-scan: the new segments appear on the next cycle for the current digit;
//   no tear within a digit beyond that single cycle.
//  Async reset asserted mid-frame: partial frame discarded; display blank until the next
//   valid frame.
// CONFIGURATION
//  DISPLAY_DIM_EN defined: adds port i_brightness in 3 plus a free-running 3-bit PWM counter.
//   Digit enabled only while pwm_cnt < i_brightness, so 0 = off and 7 = 7/8 duty.
//   Brightness applies on top of blanking and i_en.
//  DISPLAY_DIM_EN undefined: no port, no counter; full duty outside blanking.
// STRUCTURE
//  Package display_pkg: NUM_DIGITS=6, SEG_BITS=8, FRAME_BITS=48, BIT_CNT_W=6,
//   SEG_DP/SEG_G..SEG_A index localparams, digit index typedef.
//  Sub-module serial_edge_sync (2-FF sync + rising-edge pulse), instantiated 3x
//   (data uses level output only).
//  Top holds the deserialiser, frame validation, scan prescaler/FSM and output registers.
// TESTING
//  1. Shift 48 bits of 0x3F06_5B4F_6677 at 1 MHz, then latch
//     -> o_frame_stb once; digit5 = 0x3F, digit0 = 0x77.
//  2. Shift 47 bits, then latch -> o_frame_err once; frame_reg and display unchanged.
//     A following 48-bit frame is accepted.
//  3. Check the scan: o_digit_sel walks 000001..100000 and wraps.
//     Each digit is preceded by 16 cycles of 0; period = SYS_CLK_HZ/SCAN_HZ cycles.
//  4. Drop i_en mid-scan -> outputs 0 within 1 cycle.
//     Frame shifted while disabled is committed; scan resumes at the same idx when i_en = 1.
//  5. Assert reset after 20 bits, release, send a full frame
//     -> all outputs 0 until the new frame is committed; o_frame_err never fires.
//  6. DISPLAY_DIM_EN, i_brightness=3 -> digit active 3 of every 8 cycles;
//     i_brightness=0 -> o_digit_sel stays 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the serial 7-segment display consumer.
// Optional brightness PWM is enabled by defining DISPLAY_DIM_EN.
package display_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int SEG_BITS   = 8;
   localparam int FRAME_BITS = NUM_DIGITS * SEG_BITS;
   localparam int BIT_CNT_W  = 6;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef logic [2:0] digit_idx_t;

   typedef enum logic {
      ST_DARK,
      ST_SHOW
   } disp_state_t;

   function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
      return NUM_DIGITS'(1) << idx;
   endfunction

endpackage

// File: rtl/serial_edge_sync.sv
// Two-flop synchroniser for one asynchronous serial pin,
// with a single-cycle rising-edge pulse.
module serial_edge_sync (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= i_async;
         sync <= meta;
         prev <= sync;
      end
   end

   assign o_level = sync;
   assign o_rise  = sync & ~prev;

endmodule

// File: rtl/serial_display_mux.sv
// Deserialises 48-bit display frames and scans a 6-digit common-cathode display.
// Define DISPLAY_DIM_EN to add the i_brightness PWM dimming input.
module serial_display_mux
   import display_pkg::*;
#(
   parameter int SYS_CLK_HZ   = 5_000_000,
   parameter int SCAN_HZ      = 6_000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_en,
`ifdef DISPLAY_DIM_EN
   input  logic [2:0]            i_brightness,
`endif
   input  logic                  i_serial_data,
   input  logic                  i_serial_clk,
   input  logic                  i_serial_latch,
   output logic [SEG_BITS-1:0]   o_segments,
   output logic [NUM_DIGITS-1:0] o_digit_sel,
   output logic                  o_frame_stb,
   output logic                  o_frame_err
);

   localparam int SCAN_PERIOD = SYS_CLK_HZ / SCAN_HZ;
   localparam int PRESC_W     = $clog2(SCAN_PERIOD);
   localparam int BLANK_W     = $clog2(BLANK_CYCLES + 1);

   logic data_sync;
   logic data_rise_unused;
   logic clk_rise;
   logic latch_rise;
   logic clk_lvl_unused;
   logic latch_lvl_unused;

   serial_edge_sync u_sync_data (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_async   (i_serial_data),
      .o_level   (data_sync),
      .o_rise    (data_rise_unused)
   );

   serial_edge_sync u_sync_clk (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_async   (i_serial_clk),
      .o_level   (clk_lvl_unused),
      .o_rise    (clk_rise)
   );

   serial_edge_sync u_sync_latch (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_async   (i_serial_latch),
      .o_level   (latch_lvl_unused),
      .o_rise    (latch_rise)
   );

   logic [FRAME_BITS-1:0] shift_reg;
   logic [FRAME_BITS-1:0] shift_nxt;
   logic [FRAME_BITS-1:0] frame_reg;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic [BIT_CNT_W-1:0]  cnt_nxt;
   logic                  frame_ok;

   // A latch in the same cycle as a shift sees the post-shift state.
   always_comb begin
      shift_nxt = shift_reg;
      cnt_nxt   = bit_cnt;
      if (clk_rise) begin
         shift_nxt = {shift_reg[FRAME_BITS-2:0], data_sync};
         if (bit_cnt != '1) cnt_nxt = bit_cnt + 1'b1;
      end
   end

   assign frame_ok = latch_rise && (cnt_nxt == BIT_CNT_W'(FRAME_BITS));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         frame_reg   <= '0;
         o_frame_stb <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         shift_reg   <= shift_nxt;
         bit_cnt     <= latch_rise ? '0 : cnt_nxt;
         o_frame_stb <= frame_ok;
         o_frame_err <= latch_rise && !frame_ok;
         if (frame_ok) frame_reg <= shift_nxt;
      end
   end

   logic [PRESC_W-1:0] presc;
   logic [BLANK_W-1:0] blank_cnt;
   digit_idx_t         idx;
   logic               wrap;

   assign wrap = i_en && (presc == PRESC_W'(SCAN_PERIOD - 1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         presc     <= '0;
         idx       <= '0;
         blank_cnt <= '0;
      end else begin
         if (i_en) presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) begin
            idx       <= (idx == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            blank_cnt <= BLANK_W'(BLANK_CYCLES);
         end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
         end
      end
   end

   logic pwm_on;
`ifdef DISPLAY_DIM_EN
   logic [2:0] pwm_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) pwm_cnt <= '0;
      else            pwm_cnt <= pwm_cnt + 1'b1;
   end

   assign pwm_on = pwm_cnt < i_brightness;
`else
   assign pwm_on = 1'b1;
`endif

   disp_state_t           state;
   disp_state_t           state_nxt;
   logic [SEG_BITS-1:0]   seg_nxt;
   logic [NUM_DIGITS-1:0] sel_nxt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_DARK;
      else            state <= state_nxt;
   end

   // Display stays dark after reset until a valid frame arrives.
   always_comb begin
      state_nxt = state;
      seg_nxt   = '0;
      sel_nxt   = '0;
      unique case (state)
         ST_DARK: if (frame_ok) state_nxt = ST_SHOW;
         ST_SHOW: begin
            if (i_en && blank_cnt == '0 && pwm_on) begin
               sel_nxt = digit_onehot(idx);
               seg_nxt = frame_reg[{idx, 3'b000} +: SEG_BITS];
            end
         end
         default: state_nxt = ST_DARK;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_segments  <= '0;
         o_digit_sel <= '0;
      end else begin
         o_segments  <= seg_nxt;
         o_digit_sel <= sel_nxt;
      end
   end

endmodule

// File: tb/tb_serial_display_mux.sv
// Scoreboard bench for serial_display_mux: frame events and scanned digits.
`timescale 1ns/1ps
module tb_serial_display_mux;
   import display_pkg::*;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic en     = 1'b0;
   logic sdata  = 1'b0;
   logic sclk   = 1'b0;
   logic slatch = 1'b0;
`ifdef DISPLAY_DIM_EN
   logic [2:0] bright = 3'd7;
`endif
   logic [7:0] seg;
   logic [5:0] sel;
   logic stb;
   logic err;

   always #100 clk = ~clk;

   serial_display_mux dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_en           (en),
`ifdef DISPLAY_DIM_EN
      .i_brightness   (bright),
`endif
      .i_serial_data  (sdata),
      .i_serial_clk   (sclk),
      .i_serial_latch (slatch),
      .o_segments     (seg),
      .o_digit_sel    (sel),
      .o_frame_stb    (stb),
      .o_frame_err    (err)
   );

   typedef enum {EV_STB, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [47:0] frame;
   } ev_t;

   ev_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   logic [47:0] exp_frame = '0;
   bit          exp_shown = 1'b0;
   logic        en_s = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_s <= en;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (!exp_shown || !en_s) begin
            check("dark_sel", 64'(sel), 64'd0);
            check("dark_seg", 64'(seg), 64'd0);
         end else if (sel != '0) begin
            check("sel_onehot", 64'($onehot(sel)), 64'd1);
            for (int k = 0; k < 6; k++)
               if (sel[k]) check("digit_seg", 64'(seg), 64'(exp_frame[8*k +: 8]));
         end
         if (stb || err) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: got stb=%0b err=%0b, expected none",
                        stb, err);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check("event_kind", 64'({stb, err}),
                     (e.kind == EV_STB) ? 64'd2 : 64'd1);
               if (stb) begin
                  exp_frame = e.frame;
                  exp_shown = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [47:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         sdata = (i < 48) ? v[47 - i] : 1'b0;
         tick(2);
         sclk = 1'b1;
         tick(3);
         sclk = 1'b0;
      end
   endtask

   task automatic do_latch(input ev_kind_t k, input logic [47:0] f);
      exp_q.push_back('{k, f});
      tick(2);
      slatch = 1'b1;
      tick(3);
      slatch = 1'b0;
      tick(3);
   endtask

   task automatic wait_events();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         tick(1);
         t++;
      end
      check("event_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_sel(input logic [5:0] v, input bit eq, input int lim,
                           input string name);
      int t = 0;
      while (((sel == v) != eq) && t < lim) begin
         tick(1);
         t++;
      end
      check(name, 64'(t < lim), 64'd1);
   endtask

   task automatic check_scan();
      logic [5:0] prev;
      longint     t0;
      int         z;
      wait_sel(6'd0, 1'b1, 1000, "scan_wait_blank");
      wait_sel(6'd0, 1'b0, 100, "scan_wait_digit");
      prev = sel;
      t0   = cyc;
      for (int d = 0; d < 7; d++) begin
         wait_sel(6'd0, 1'b1, 1000, "scan_wait_blank");
         z = 0;
         while (sel == '0 && z < 100) begin
            tick(1);
            z++;
         end
         check("blank_len", 64'(z), 64'd16);
         check("scan_period", 64'(cyc - t0), 64'd833);
         check("digit_walk", 64'(sel), 64'({prev[4:0], prev[5]}));
         prev = sel;
         t0   = cyc;
      end
   endtask

   initial begin
      logic [5:0] saved;
      int         cnt;

      tick(5);
      check("reset_seg", 64'(seg), 64'd0);
      check("reset_sel", 64'(sel), 64'd0);
      check("reset_stb", 64'(stb), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      en    = 1'b1;
      tick(5);

      send_bits(48'h3F06_5B4F_6677, 48);
      do_latch(EV_STB, 48'h3F06_5B4F_6677);
      wait_events();
      wait_sel(6'b100000, 1'b1, 6000, "wait_digit5");
      check("digit5_value", 64'(seg), 64'h3F);
      wait_sel(6'b000001, 1'b1, 6000, "wait_digit0");
      check("digit0_value", 64'(seg), 64'h77);

      send_bits(48'h1111_1111_1111, 47);
      do_latch(EV_ERR, '0);
      do_latch(EV_ERR, '0);
      send_bits(48'h2222_2222_2222, 49);
      do_latch(EV_ERR, '0);
      send_bits(48'h3333_3333_3333, 70);
      do_latch(EV_ERR, '0);
      wait_events();
      wait_sel(6'b100000, 1'b1, 6000, "wait_digit5_kept");
      check("digit5_kept", 64'(seg), 64'h3F);

      send_bits(48'h066D_7D07_7F6F, 48);
      do_latch(EV_STB, 48'h066D_7D07_7F6F);
      wait_events();

      send_bits(48'h5B4F_6607_7F3F, 47);
      sdata = 1'b1;
      exp_q.push_back('{EV_STB, 48'h5B4F_6607_7F3F});
      tick(2);
      sclk   = 1'b1;
      slatch = 1'b1;
      tick(3);
      sclk   = 1'b0;
      slatch = 1'b0;
      tick(3);
      wait_events();
      wait_sel(6'b000001, 1'b1, 6000, "wait_digit0_same");
      check("same_cycle_digit0", 64'(seg), 64'h3F);

`ifndef DISPLAY_DIM_EN
      check_scan();
`endif

      wait_sel(6'd0, 1'b0, 2000, "en_wait_digit");
      tick(100);
      saved = sel;
      en = 1'b0;
      tick(1);
      check("en_off_sel", 64'(sel), 64'd0);
      check("en_off_seg", 64'(seg), 64'd0);
      send_bits(48'h7F3F_064F_5B66, 48);
      do_latch(EV_STB, 48'h7F3F_064F_5B66);
      wait_events();
      tick(10);
      en = 1'b1;
      wait_sel(6'd0, 1'b0, 20, "en_resume_wait");
      check("resume_idx", 64'(sel), 64'(saved));

      send_bits(48'hFFFF_FFFF_FFFF, 20);
      rst_n = 1'b0;
      exp_shown = 1'b0;
      exp_q.delete();
      tick(3);
      check("midreset_sel", 64'(sel), 64'd0);
      check("midreset_seg", 64'(seg), 64'd0);
      rst_n = 1'b1;
      tick(5);
      check("post_reset_sel", 64'(sel), 64'd0);
      send_bits(48'h0102_0408_1020, 48);
      do_latch(EV_STB, 48'h0102_0408_1020);
      wait_events();
      wait_sel(6'b000001, 1'b1, 6000, "wait_digit0_new");
      check("new_digit0", 64'(seg), 64'h20);

`ifdef DISPLAY_DIM_EN
      bright = 3'd3;
      wait_sel(6'd0, 1'b0, 2000, "dim_wait");
      tick(40);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (sel != '0) cnt++;
         tick(1);
      end
      check("dim3_duty", 64'(cnt), 64'd3);
      bright = 3'd0;
      tick(2);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (sel != '0) cnt++;
         tick(1);
      end
      check("dim0_off", 64'(cnt), 64'd0);
      bright = 3'd7;
`endif

      tick(5);
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #18_000_000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

endmodule
